uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of byte-stream requesters sharing the UART transmitter (legal 2..8).
REQ-002 Parameter ID_WIDTH, default $clog2(NUM_REQ), width of the grant index.
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 req_axiiv  input  NUM_REQ  per-requester byte valid.
REQ-006 req_axiid  input  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-007 req_axiilast  input  NUM_REQ  per-requester last-byte-of-packet flag, qualified by req_axiiv.
REQ-008 req_axiready  output  NUM_REQ  per-requester accept, combinational.
REQ-009 uart_axiov  output  1  byte valid to UART transmitter.
REQ-010 uart_axiod  output  8  byte to UART transmitter.
REQ-011 uart_axiready  input  1  UART transmitter can take a byte.
REQ-012 grant_id  output  ID_WIDTH  index of the currently or most recently granted requester.
REQ-013 busy  output  1  high while a packet is in progress or the output buffer is full.

Function
REQ-014 Requester byte transfer: a byte from requester i SHALL transfer on a cycle where req_axiiv[i] and req_axiready[i] are both high.
REQ-015 UART byte transfer: a byte to the UART SHALL transfer on a cycle where uart_axiov and uart_axiready are both high.
REQ-016 One-entry registered output buffer: uart_axiov is high exactly while the buffer is full; uart_axiod SHALL be stable while uart_axiov is high and not yet accepted.
REQ-017 The buffer SHALL be "free" on a cycle when it is empty, or when it is full and being drained that cycle.
REQ-018 States SHALL be IDLE, HEADER and PASS. HEADER SHALL exist only when the macro in REQ-030 is defined.
REQ-019 IDLE arbitration: if any req_axiiv is high, grant the first asserted requester in round-robin order starting at (last_grant+1) mod NUM_REQ.
  - grant_id SHALL update on that edge.
  - The next state SHALL be HEADER (macro defined) or PASS.
  - No byte SHALL be accepted in IDLE.
REQ-020 PASS:
  - req_axiready[grant_id] = buffer free; all other req_axiready bits SHALL be 0.
  - An accepted byte SHALL appear on uart_axiod with uart_axiov high from the next cycle (latency 1).
REQ-021 End of packet: accepting a byte in PASS with req_axiilast high SHALL set last_grant <= grant_id and move the state to IDLE.
  - Consequence: one idle cycle between back-to-back packets.
REQ-022 Stall: the granted requester dropping req_axiiv mid-packet SHALL NOT release the grant; the arbiter waits indefinitely in PASS.
REQ-023 Valid without last: requests from non-granted requesters SHALL be ignored, and their req_axiready SHALL stay 0, until the packet ends.
REQ-024 Single-byte packet: req_axiilast high on the first byte SHALL be a legal complete packet.
REQ-025 Full throughput: with uart_axiready held high, PASS SHALL sustain one byte per cycle.
REQ-026 busy = (state != IDLE) | uart_axiov.

Reset
REQ-027 While rst is low at a clock edge, the following SHALL be forced on that edge, including mid-packet; a partially sent packet is abandoned:
  - state = IDLE
  - buffer emptied: uart_axiov = 0, uart_axiod = 8'h00
  - grant_id = 0
  - last_grant = NUM_REQ-1, so requester 0 has first priority
REQ-028 During reset all req_axiready bits SHALL be 0.
REQ-029 After reset, busy SHALL be 0.

Configuration
REQ-030 Macro UART_ARB_HEADER_EN, when defined: HEADER state loads 8'hA0 | grant_id into the buffer as soon as the buffer is free, then moves to PASS.
  - req_axiready stays 0 in HEADER.
  - Every packet on the UART is prefixed by its requester ID byte.
REQ-031 UART_ARB_HEADER_EN undefined: HEADER logic SHALL be absent, IDLE SHALL go directly to PASS, and UART output SHALL be the raw concatenation of packets.

Verification
REQ-032 Reset, macro undefined, uart_axiready=1: requester 0 sends {8'h11, 8'h22(last)} -> uart_axiod 8'h11 then 8'h22 on consecutive cycles; grant_id=0; busy low two cycles after the last accept.
REQ-033 Reset, macro undefined: both requesters continuously send 2-byte packets -> grant_id order is 0,1,0,1; packets are never interleaved.
REQ-034 uart_axiready held 0 for 10 cycles while requester 1 offers bytes -> exactly one byte is buffered; req_axiready[1]=0 until uart_axiready rises; the byte stream is intact afterwards.
REQ-035 Macro defined: requester 1 sends 8'h5C(last) -> UART sees 8'hA1 then 8'h5C.
REQ-036 rst driven low for one cycle after byte 2 of a 4-byte packet from requester 1, then requester 0 requests -> uart_axiov is 0 the cycle after reset; requester 0 is granted first; no stale byte is emitted.
REQ-037 Granted requester drops req_axiiv for 5 cycles mid-packet while requester 0 requests -> grant_id stays unchanged and req_axiready[0] stays 0 throughout.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that multiplexes byte-stream packets from NUM_REQ requesters onto one UART transmitter.
// Optional macro UART_ARB_HEADER_EN prefixes each packet with an ID byte (8'hA0 | grant_id).
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_axiiv,
  input  logic [8*NUM_REQ-1:0]   req_axiid,
  input  logic [NUM_REQ-1:0]     req_axiilast,
  output logic [NUM_REQ-1:0]     req_axiready,
  output logic                   uart_axiov,
  output logic [7:0]             uart_axiod,
  input  logic                   uart_axiready,
  output logic [ID_WIDTH-1:0]    grant_id,
  output logic                   busy
);

  localparam int unsigned BYTE_W = 8;

`ifdef UART_ARB_HEADER_EN
  localparam logic [BYTE_W-1:0] HDR_BASE = 8'hA0;
  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PASS} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_PASS} state_t;
`endif

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] grant_q, grant_d;
  logic [ID_WIDTH-1:0] last_grant_q, last_grant_d;
  logic                buf_valid_q, buf_valid_d;
  logic [BYTE_W-1:0]   buf_data_q, buf_data_d;

  logic [BYTE_W-1:0]   req_byte [NUM_REQ];
  logic                buf_free;
  logic                pick_found;
  logic [ID_WIDTH-1:0] pick_id;
  logic [31:0]         rr_idx;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_byte[g] = req_axiid[BYTE_W*g +: BYTE_W];
  end

  assign buf_free = !buf_valid_q || uart_axiready;

  // First valid requester in round-robin order after the last completed grant
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    rr_idx     = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      rr_idx = 32'(last_grant_q) + 32'(i);
      if (rr_idx >= 32'(NUM_REQ)) rr_idx = rr_idx - 32'(NUM_REQ);
      if (!pick_found && req_axiiv[ID_WIDTH'(rr_idx)]) begin
        pick_found = 1'b1;
        pick_id    = ID_WIDTH'(rr_idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    buf_valid_d  = buf_valid_q && !uart_axiready;
    buf_data_d   = buf_data_q;
    req_axiready = '0;

    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d = pick_id;
`ifdef UART_ARB_HEADER_EN
          state_d = S_HEADER;
`else
          state_d = S_PASS;
`endif
        end
      end
`ifdef UART_ARB_HEADER_EN
      S_HEADER: begin
        if (buf_free) begin
          buf_valid_d = 1'b1;
          buf_data_d  = HDR_BASE | BYTE_W'(grant_q);
          state_d     = S_PASS;
        end
      end
`endif
      S_PASS: begin
        // Ready is masked while reset is asserted so nothing appears accepted
        req_axiready[grant_q] = buf_free && rst;
        if (req_axiiv[grant_q] && buf_free) begin
          buf_valid_d = 1'b1;
          buf_data_d  = req_byte[grant_q];
          if (req_axiilast[grant_q]) begin
            last_grant_d = grant_q;
            state_d      = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
      buf_valid_q  <= 1'b0;
      buf_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      buf_valid_q  <= buf_valid_d;
      buf_data_q   <= buf_data_d;
    end
  end

  assign uart_axiov = buf_valid_q;
  assign uart_axiod = buf_data_q;
  assign grant_id   = grant_q;
  assign busy       = (state_q != S_IDLE) || buf_valid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with two requesters; expected streams and grants are hand-computed.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_axiiv;
  logic [15:0] req_axiid;
  logic [1:0]  req_axiilast;
  logic [1:0]  req_axiready;
  logic        uart_axiov;
  logic [7:0]  uart_axiod;
  logic        uart_axiready;
  logic [0:0]  grant_id;
  logic        busy;

  uart_tx_arbiter #(.NUM_REQ(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_axiiv     (req_axiiv),
    .req_axiid     (req_axiid),
    .req_axiilast  (req_axiilast),
    .req_axiready  (req_axiready),
    .uart_axiov    (uart_axiov),
    .uart_axiod    (uart_axiod),
    .uart_axiready (uart_axiready),
    .grant_id      (grant_id),
    .busy          (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;

  // Per-requester packet queues: {last, data}
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic       en0, en1;
  logic [1:0] rdy_seen;
  logic [7:0] stream_q[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) begin
    if (rst === 1'b1 && uart_axiov === 1'b1 && uart_axiready === 1'b1)
      stream_q.push_back(uart_axiod);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    assert (got === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, expv);
    end
  endtask

  // One clock: drive from queues, capture ready before the edge, pop accepted bytes after it
  task automatic cycle();
    logic [1:0] acc;
    req_axiiv[0]    = en0 && (q0.size() > 0);
    req_axiiv[1]    = en1 && (q1.size() > 0);
    req_axiid[7:0]  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
    req_axiid[15:8] = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
    req_axiilast[0] = (q0.size() > 0) ? q0[0][8] : 1'b0;
    req_axiilast[1] = (q1.size() > 0) ? q1[0][8] : 1'b0;
    #1;
    rdy_seen = req_axiready;
    acc      = req_axiiv & req_axiready;
    @(posedge clk);
    #1;
    if (acc[0]) void'(q0.pop_front());
    if (acc[1]) void'(q1.pop_front());
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_len"}, 32'(stream_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < stream_q.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), 32'(stream_q[i]), 32'(exp_q[i]));
    stream_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cycle();
    chk("rst_ready", 32'(rdy_seen), 32'h0);
    cycle();
    rst = 1'b1;
    chk("rst_ov", 32'(uart_axiov), 32'h0);
    chk("rst_od", 32'(uart_axiod), 32'h00);
    chk("rst_gid", 32'(grant_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
  endtask

  initial begin
    rst = 1'b0; req_axiiv = '0; req_axiid = '0; req_axiilast = '0;
    uart_axiready = 1'b1; en0 = 1'b0; en1 = 1'b0;
    @(posedge clk); #1;
    do_reset();

`ifdef UART_ARB_HEADER_EN
    // Requester 1 single-byte packet is prefixed by its ID byte
    en1 = 1'b1; q1.push_back({1'b1, 8'h5C});
    cycle(); chk("hdr_gid", 32'(grant_id), 32'h1);
    cycle(); chk("hdr_ov", 32'(uart_axiov), 32'h1); chk("hdr_od", 32'(uart_axiod), 32'hA1);
    chk("hdr_rdy", 32'(rdy_seen), 32'h0);
    cycle(); chk("hdr_od2", 32'(uart_axiod), 32'h5C);
    cycle(); cycle();
    chk("hdr_busy", 32'(busy), 32'h0);
    exp_q = '{8'hA1, 8'h5C};
    check_stream("hdr_stream");
`else
    // Two-byte packet from requester 0
    en0 = 1'b1; q0.push_back({1'b0, 8'h11}); q0.push_back({1'b1, 8'h22});
    cycle();
    chk("t1_idle_rdy", 32'(rdy_seen), 32'h0);
    chk("t1_gid", 32'(grant_id), 32'h0);
    chk("t1_busy_pass", 32'(busy), 32'h1);
    chk("t1_ov0", 32'(uart_axiov), 32'h0);
    cycle();
    chk("t1_rdy", 32'(rdy_seen), 32'h1);
    chk("t1_ov1", 32'(uart_axiov), 32'h1);
    chk("t1_od1", 32'(uart_axiod), 32'h11);
    cycle();
    chk("t1_od2", 32'(uart_axiod), 32'h22);
    chk("t1_busy_buf", 32'(busy), 32'h1);
    cycle();
    chk("t1_ov_end", 32'(uart_axiov), 32'h0);
    chk("t1_busy_end", 32'(busy), 32'h0);
    exp_q = '{8'h11, 8'h22};
    check_stream("t1_stream");

    // Both requesters send two 2-byte packets: strict alternation, no interleave
    do_reset();
    en0 = 1'b1; en1 = 1'b1;
    q0 = '{9'h040, 9'h141, 9'h042, 9'h143};
    q1 = '{9'h080, 9'h181, 9'h082, 9'h183};
    for (int p = 0; p < 4; p++) begin
      cycle();
      chk($sformatf("t2_gid%0d", p), 32'(grant_id), 32'(p % 2));
      cycle();
      cycle();
    end
    cycle(); cycle();
    exp_q = '{8'h40, 8'h41, 8'h80, 8'h81, 8'h42, 8'h43, 8'h82, 8'h83};
    check_stream("t2_stream");

    // UART stalls for 10 cycles: only one byte is buffered
    en0 = 1'b0; en1 = 1'b1; uart_axiready = 1'b0;
    q1 = '{9'h0C0, 9'h0C1, 9'h1C2};
    cycle();
    chk("t3_gid", 32'(grant_id), 32'h1);
    cycle();
    chk("t3_rdy_first", 32'(rdy_seen), 32'h2);
    for (int i = 0; i < 9; i++) begin
      cycle();
      chk($sformatf("t3_stall_rdy%0d", i), 32'(rdy_seen), 32'h0);
      chk($sformatf("t3_stall_od%0d", i), {23'h0, uart_axiov, uart_axiod}, 32'h1C0);
    end
    chk("t3_q_left", 32'(q1.size()), 32'd2);
    uart_axiready = 1'b1;
    cycle();
    chk("t3_rdy_resume", 32'(rdy_seen), 32'h2);
    cycle(); cycle(); cycle();
    chk("t3_q_done", 32'(q1.size()), 32'd0);
    exp_q = '{8'hC0, 8'hC1, 8'hC2};
    check_stream("t3_stream");

    // Granted requester stalls mid-packet while requester 0 waits
    q1 = '{9'h0D0, 9'h0D1, 9'h1D2};
    cycle();
    chk("t4_gid", 32'(grant_id), 32'h1);
    cycle();
    en1 = 1'b0; en0 = 1'b1; q0 = '{9'h1E0};
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk($sformatf("t4_hold_gid%0d", i), 32'(grant_id), 32'h1);
      chk($sformatf("t4_hold_rdy0_%0d", i), 32'(rdy_seen[0]), 32'h0);
    end
    en1 = 1'b1;
    cycle(); cycle();
    cycle();
    chk("t4_gid_next", 32'(grant_id), 32'h0);
    cycle(); cycle(); cycle();
    exp_q = '{8'hD0, 8'hD1, 8'hD2, 8'hE0};
    check_stream("t4_stream");

    // Reset mid-packet abandons the packet and restores requester 0 priority
    en0 = 1'b0; en1 = 1'b1;
    q1 = '{9'h0F0, 9'h0F1, 9'h0F2, 9'h1F3};
    cycle();
    chk("t5_gid", 32'(grant_id), 32'h1);
    cycle(); cycle();
    chk("t5_od_pre", 32'(uart_axiod), 32'hF1);
    rst = 1'b0; uart_axiready = 1'b0;
    cycle();
    chk("t5_rst_rdy", 32'(rdy_seen), 32'h0);
    chk("t5_ov_after", 32'(uart_axiov), 32'h0);
    chk("t5_od_after", 32'(uart_axiod), 32'h00);
    chk("t5_busy_after", 32'(busy), 32'h0);
    rst = 1'b1; uart_axiready = 1'b1;
    en0 = 1'b1; q0 = '{9'h1A5}; q1 = '{9'h1B1};
    cycle();
    chk("t5_first_gid", 32'(grant_id), 32'h0);
    cycle();
    cycle();
    chk("t5_second_gid", 32'(grant_id), 32'h1);
    cycle(); cycle(); cycle();
    exp_q = '{8'hF0, 8'hA5, 8'hB1};
    check_stream("t5_stream");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
